// File: rtl/root_sched_pkg.sv
// root_sched_pkg: shared state type and widths for the root engine scheduler
package root_sched_pkg;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, FAULT} state_e;

    localparam int BASE_W = 10;
    localparam int EXP_W  = 3;
    localparam int DATA_W = 20;

    // Timeout counter must be able to hold the value TIMEOUT itself
    function automatic int cnt_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching from the slot after last_grant
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_grant,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id
);

    // Scan from farthest to nearest offset so the closest requester after last_grant wins
    always_comb begin
        int j;
        logic [ID_W-1:0] idx;
        grant    = '0;
        grant_id = '0;
        j        = 0;
        idx      = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            j   = int'(last_grant) + i;
            j   = (j >= N_REQ) ? j - N_REQ : j;
            idx = ID_W'(j);
            if (en && req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end

endmodule

// File: rtl/root_sched.sv
// root_sched: round-robin sharing of one root engine with operand hold, id tagging and hang guard
module root_sched
    import root_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*BASE_W-1:0] req_base,
    input  logic [N_REQ*EXP_W-1:0]  req_exp,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_error,
    output logic                    eng_in_valid,
    output logic [BASE_W-1:0]       eng_in_data_1,
    output logic [EXP_W-1:0]        eng_in_data_2,
    input  logic                    eng_out_valid,
    input  logic [DATA_W-1:0]       eng_out_data,
    output logic                    eng_fault
);

    localparam int CNT_W = cnt_w(TIMEOUT);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [BASE_W-1:0]  base_q, base_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               err_q, err_d;
    logic               fault_q, fault_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]   gnt;
    logic [ID_W-1:0]    gnt_id;
    logic [BASE_W-1:0]  sel_base;
    logic [EXP_W-1:0]   sel_exp;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req        (req_valid),
        .last_grant (last_q),
        .en         (state_q == IDLE || state_q == FAULT),
        .grant      (gnt),
        .grant_id   (gnt_id)
    );

    assign sel_base      = req_base[int'(gnt_id)*BASE_W +: BASE_W];
    assign sel_exp       = req_exp[int'(gnt_id)*EXP_W +: EXP_W];
    assign req_ready     = gnt & {N_REQ{rst_n}};
    assign rsp_valid     = state_q == RESP;
    assign eng_in_valid  = state_q == ISSUE;
    assign rsp_id        = id_q;
    assign rsp_data      = data_q;
    assign rsp_error     = err_q;
    assign eng_in_data_1 = base_q;
    assign eng_in_data_2 = exp_q;
    assign eng_fault     = fault_q;

    // Next-state logic: accept, issue, wait with timeout, hold response
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        base_d  = base_q;
        exp_d   = exp_q;
        data_d  = data_q;
        err_d   = err_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, FAULT: begin
                if (|gnt) begin
                    last_d  = gnt_id;
                    id_d    = gnt_id;
                    data_d  = '0;
                    err_d   = (state_q == FAULT) || (sel_exp == '0);
                    state_d = ((state_q == FAULT) || (sel_exp == '0)) ? RESP : ISSUE;
                    if (state_q == IDLE) begin
                        base_d = sel_base;
                        exp_d  = sel_exp;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (eng_out_valid) begin
                    data_d  = eng_out_data;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    fault_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = fault_q ? FAULT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= ID_W'(N_REQ - 1);
            id_q    <= '0;
            base_q  <= '0;
            exp_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            base_q  <= base_d;
            exp_q   <= exp_d;
            data_q  <= data_d;
            err_q   <= err_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
